// File: rtl/nv_ram_rwsp_gen.sv
// rtl/nv_ram_rwsp_gen.sv - parametrised 1R1W register-file RAM with init sweep, bypass, sleep and sticky errors
module nv_ram_rwsp_gen #(
    parameter int DW         = 16,
    parameter int DEPTH      = 80,
    parameter int AW         = 7,
    parameter int MW         = 8,
    parameter bit BYPASS     = 1'b1,
    parameter bit INIT_CLEAR = 1'b1,
    localparam int NL        = DW / MW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] ra,
    input  logic          re,
    input  logic          ore,
    output logic [DW-1:0] dout,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [NL-1:0] wmask,
    input  logic [DW-1:0] di,
    input  logic [31:0]   pwrbus_ram_pd,
    output logic          init_done,
    output logic          err_oor,
    output logic          err_busy,
    input  logic          err_clr
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam state_t        RST_STATE = INIT_CLEAR ? ST_INIT : ST_READY;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] ra_d;
    logic          sleep, ready, wa_ok, ra_ok, wr_en, byp_hit, set_oor, set_busy;
    logic [DW-1:0] rd_word, byp_word;
    logic          unused_pd;

    assign unused_pd = ^pwrbus_ram_pd[31:1];

    always_comb begin
        sleep    = pwrbus_ram_pd[0];
        ready    = (state == ST_READY);
        wa_ok    = ({1'b0, wa} < DEPTH_W);
        ra_ok    = ({1'b0, ra_d} < DEPTH_W);
        wr_en    = ready && !sleep && we && wa_ok;
        rd_word  = ra_ok ? mem[ra_d] : '0;
        // Forwarded word: written lanes from di, the rest from the pre-write array contents
        byp_hit  = BYPASS && wr_en && (wa == ra_d);
        byp_word = rd_word;
        for (int i = 0; i < NL; i++) begin
            if (wmask[i]) byp_word[i*MW +: MW] = di[i*MW +: MW];
        end
        set_oor  = ready && !sleep && ((we && !wa_ok) || (ore && !ra_ok));
        set_busy = (we || re) && (sleep || !ready);
    end

    // Array contents are deliberately not reset; the INIT sweep clears them
    always_ff @(posedge clk) begin
        if (rstn && !sleep) begin
            if (!ready) begin
                mem[cnt] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NL; i++) begin
                    if (wmask[i]) mem[wa][i*MW +: MW] <= di[i*MW +: MW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RST_STATE;
            cnt       <= '0;
            ra_d      <= '0;
            dout      <= '0;
            init_done <= !INIT_CLEAR;
            err_oor   <= 1'b0;
            err_busy  <= 1'b0;
        end else begin
            init_done <= ready;
            err_oor   <= set_oor  | (err_oor  & ~err_clr);
            err_busy  <= set_busy | (err_busy & ~err_clr);
            if (!sleep) begin
                if (state == ST_INIT) begin
                    if (ore) dout <= '0;
                    if (cnt == LAST) state <= ST_READY;
                    else             cnt   <= cnt + 1'b1;
                end else begin
                    if (re)  ra_d <= ra;
                    if (ore) dout <= byp_hit ? byp_word : rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_gen.sv
// tb/tb_nv_ram_rwsp_gen.sv - scoreboard bench for nv_ram_rwsp_gen against a behavioural RAM model
module tb_nv_ram_rwsp_gen;

    localparam int DW = 16, DEPTH = 80, AW = 7, MW = 8, NL = 2;
    localparam bit BYP = 1'b1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] ra = '0, wa = '0;
    logic          re = 1'b0, ore = 1'b0, we = 1'b0, err_clr = 1'b0;
    logic [NL-1:0] wmask = '0;
    logic [DW-1:0] di = '0;
    logic [31:0]   pd = '0;
    logic [DW-1:0] dout;
    logic          init_done, err_oor, err_busy;

    always #5 clk = ~clk;

    nv_ram_rwsp_gen #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .MW(MW), .BYPASS(BYP), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pd),
        .init_done(init_done), .err_oor(err_oor), .err_busy(err_busy), .err_clr(err_clr)
    );

    logic [DW-1:0] mm [DEPTH];
    int            rad, init_left;
    bit            m_oor, m_busy, m_done;
    logic [DW-1:0] exp_q [$];
    int            checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [NL-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < NL; i++) if (m[i]) r[i*MW +: MW] = nw[i*MW +: MW];
        return r;
    endfunction

    task automatic mreset();
        init_left = DEPTH;
        rad = 0; m_oor = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic idle();
        we = 0; re = 0; ore = 0; err_clr = 0; pd = '0; wmask = '0;
    endtask

    // Apply the current inputs to the model for one edge, then check flags after the edge
    task automatic step();
        bit s_oor, s_busy, rdy;
        logic [DW-1:0] rd, e;
        s_oor = 0; s_busy = 0;
        rdy = (init_left == 0);
        if (pd[0]) begin
            s_busy = we | re;
        end else if (!rdy) begin
            s_busy = we | re;
            if (ore) exp_q.push_back('0);
            mm[DEPTH - init_left] = '0;
            init_left--;
        end else begin
            rd = (rad < DEPTH) ? mm[rad] : '0;
            if (ore) begin
                e = rd;
                if (rad >= DEPTH) s_oor = 1;
                else if (BYP && we && int'(wa) == rad) e = merge(rd, di, wmask);
                exp_q.push_back(e);
            end
            if (we) begin
                if (wa < DEPTH) mm[wa] = merge(mm[wa], di, wmask);
                else s_oor = 1;
            end
            if (re) rad = int'(ra);
        end
        m_oor  = s_oor  | (m_oor  & !err_clr);
        m_busy = s_busy | (m_busy & !err_clr);
        m_done = rdy;
        @(negedge clk);
        chk("init_done", {31'b0, init_done}, {31'b0, m_done});
        chk("err_oor",   {31'b0, err_oor},   {31'b0, m_oor});
        chk("err_busy",  {31'b0, err_busy},  {31'b0, m_busy});
    endtask

    // Monitor: every capture edge the DUT accepts is matched against the oldest expected word
    initial begin
        bit take;
        forever begin
            @(posedge clk);
            take = rstn && ore && !pd[0];
            @(negedge clk);
            if (take) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dout_unexpected actual=%h expected=none t=%0t", dout, $time);
                end else begin
                    chk("dout", {16'b0, dout}, {16'b0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic do_reset();
        #2 rstn = 0;
        exp_q.delete();
        #1;
        chk("dout_in_reset", {16'b0, dout}, 32'h0);
        chk("init_done_in_reset", {31'b0, init_done}, 32'h0);
        @(negedge clk);
        idle();
        mreset();
        rstn = 1;
    endtask

    task automatic wait_done(input int start, input int expect_edge, input string name);
        int n;
        n = start;
        while (!init_done && n < 300) begin
            step();
            n++;
        end
        chk(name, n, expect_edge);
    endtask

    task automatic read_all();
        for (int i = 0; i <= DEPTH; i++) begin
            re = (i < DEPTH); ra = AW'(i); ore = (i > 0);
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        mreset();
        rstn = 0;
        repeat (2) @(negedge clk);
        #1 chk("reset_dout", {16'b0, dout}, 32'h0);
        chk("reset_init_done", {31'b0, init_done}, 32'h0);
        chk("reset_err_oor", {31'b0, err_oor}, 32'h0);
        @(negedge clk);
        rstn = 1;
        wait_done(0, 81, "init_done_edge");
        read_all();

        // masked write then 2-cycle read
        we = 1; wa = 5; di = 16'hABCD; wmask = 2'b11; step();
        di = 16'h1234; wmask = 2'b01; step();
        we = 0; re = 1; ra = 5; step();
        re = 0; ore = 1; step();
        chk("masked_read", {16'b0, dout}, 32'h0000AB34);
        idle();

        // bypass collision
        we = 1; wa = 9; di = 16'h1111; wmask = 2'b11; step();
        we = 0; re = 1; ra = 9; step();
        re = 0; ore = 1; we = 1; wa = 9; di = 16'h2222; wmask = 2'b10; step();
        chk("bypass_read", {16'b0, dout}, BYP ? 32'h2211 : 32'h1111);
        we = 0; step();
        chk("bypass_followup", {16'b0, dout}, 32'h2211);
        idle();

        // out of range
        we = 1; wa = 80; di = 16'hFFFF; wmask = 2'b11; step();
        we = 0; re = 1; ra = 100; step();
        re = 0; ore = 1; step();
        chk("oor_dout", {16'b0, dout}, 32'h0);
        chk("oor_flag", {31'b0, err_oor}, 32'h1);
        ore = 0; err_clr = 1; step();
        chk("oor_cleared", {31'b0, err_oor}, 32'h0);
        idle();

        // sleep mid-INIT
        do_reset();
        repeat (40) step();
        for (int k = 0; k < 10; k++) begin
            pd = {$urandom} | 32'h1;
            we = (k % 3 == 0); wa = AW'(k);
            step();
        end
        idle();
        wait_done(50, 91, "init_done_after_sleep");
        chk("busy_after_sleep", {31'b0, err_busy}, 32'h1);
        read_all();

        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            we = $urandom_range(0, 1);
            re = $urandom_range(0, 1);
            ore = $urandom_range(0, 1);
            wa = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(80, 127)) : AW'($urandom_range(0, 79));
            ra = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(80, 127)) : AW'($urandom_range(0, 79));
            if ($urandom_range(0, 3) == 0) ra = wa;
            wmask = NL'($urandom_range(0, 3));
            di = DW'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            pd = {$urandom} & ~32'h1;
            if ($urandom_range(0, 19) == 0) pd[0] = 1'b1;
            step();
        end
        idle();

        // reset during streaming reads
        for (int k = 0; k < 10; k++) begin
            re = 1; ore = 1; ra = AW'(k); step();
        end
        do_reset();
        wait_done(0, 81, "init_done_after_traffic_reset");
        read_all();

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
